// File: rtl/gpu_isa_pkg.sv
// Shared ISA definitions: opcode encoding, instruction field positions and the
// fixed-point word width, used by the sequencer and the controller.
package gpu_isa_pkg;

  localparam int DATA_CACHE_WIDTH = 16;

  // Instruction fields, MSB-first bit numbering [0:INSTRUCTION_WIDTH-1]
  localparam int OPC_START   = 0;
  localparam int OPC_END     = 3;
  localparam int REG_A_START = 4;
  localparam int REG_A_END   = 7;
  localparam int IMM_START   = 8;
  localparam int IMM_END     = 23;
  localparam int REG_B_START = 24;
  localparam int REG_B_END   = 27;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_END       = 4'd1,
    OP_XOR       = 4'd2,
    OP_ADDI      = 4'd3,
    OP_BGE       = 4'd4,
    OP_JUMP      = 4'd5,
    OP_LOADB     = 4'd6,
    OP_LOAD      = 4'd7,
    OP_OR        = 4'd8,
    OP_SENDITERS = 4'd9,
    OP_SMA       = 4'd10,
    OP_LOADI     = 4'd11,
    OP_WRITE     = 4'd12,
    OP_SENDL     = 4'd13,
    OP_WRITEB    = 4'd14
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_WAIT = 2'd1,
    ST_ISSUE     = 2'd2
  } seq_state_e;

  // Word 0 sits at the top of the line, so word idx starts at this bit.
  function automatic int line_word_lsb(input int idx, input int word_w, input int words);
    return (words - 1 - idx) * word_w;
  endfunction

endpackage

// File: rtl/line_stager.sv
// Staging line register: holds one cache line and updates a single word per
// write; out-of-range word indices are ignored.
module line_stager
  import gpu_isa_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int WORDS  = 12
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      i_we,
  input  logic [3:0]                i_word_idx,
  input  logic [WORD_W-1:0]         i_word,
  output logic [WORD_W*WORDS-1:0]   o_line
);

  localparam int LINE_W = WORD_W * WORDS;

  logic [LINE_W-1:0] r_line;

  // Word-indexed update of the staging line
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_line <= {LINE_W{1'b0}};
    end else begin
      for (int w = 0; w < WORDS; w++) begin
        if (i_we && (int'(i_word_idx) == w)) begin
          r_line[line_word_lsb(w, WORD_W, WORDS) +: WORD_W] <= i_word;
        end
      end
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/memory_sequencer.sv
// Memory sequencer: stages cache lines, writes them to the external cache and
// streams cache lines to the FMA array. Optional MEMSEQ_DIRECT_WRITE_EN enables WRITE.
module memory_sequencer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int DATA_CACHE_WIDTH  = gpu_isa_pkg::DATA_CACHE_WIDTH,
  parameter int WORDS_PER_LINE    = 12,
  parameter int DATA_CACHE_DEPTH  = 4096,
  parameter int READ_LATENCY      = 2
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic [0:INSTRUCTION_WIDTH-1]                  instr_in,
  input  logic                                          instr_valid_in,
  output logic                                          ready_out,
  output logic [$clog2(DATA_CACHE_DEPTH)-1:0]           cache_addr_out,
  output logic [WORDS_PER_LINE*DATA_CACHE_WIDTH-1:0]    cache_wdata_out,
  output logic                                          cache_we_out,
  input  logic [WORDS_PER_LINE*DATA_CACHE_WIDTH-1:0]    cache_rdata_in,
  output logic [WORDS_PER_LINE*DATA_CACHE_WIDTH-1:0]    fma_data_out,
  output logic                                          fma_write_out,
  output logic                                          fma_replace_c_out,
  output logic                                          fma_valid_out
);

  import gpu_isa_pkg::*;

  localparam int LINE_W = WORDS_PER_LINE * DATA_CACHE_WIDTH;
  localparam int AW     = $clog2(DATA_CACHE_DEPTH);
  localparam int CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  seq_state_e        r_state;
  seq_state_e        w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [AW-1:0]     r_addr;
  logic [AW-1:0]     r_cache_addr;
  logic [LINE_W-1:0] r_cache_wdata;
  logic              r_cache_we;
  logic [LINE_W-1:0] r_fma_data;
  logic              r_fma_write;
  logic              r_replace_c;
  logic              r_fma_valid;

  logic [3:0]        w_opcode;
  logic [3:0]        w_reg_a;
  logic [3:0]        w_reg_b;
  logic [15:0]       w_imm;
  logic [AW-1:0]     w_imm_addr;
  logic [LINE_W-1:0] w_staging;
  logic              w_accept;
  logic              w_stage_we;
  logic              w_sma;
  logic              w_sendl;
  logic              w_writeb;
  logic              w_direct;
  logic              w_unused;

  assign w_opcode   = instr_in[OPC_START:OPC_END];
  assign w_reg_a    = instr_in[REG_A_START:REG_A_END];
  assign w_imm      = instr_in[IMM_START:IMM_END];
  assign w_reg_b    = instr_in[REG_B_START:REG_B_END];
  assign w_imm_addr = AW'(w_imm);
  assign w_accept   = instr_valid_in && (r_state == ST_IDLE);
  assign w_unused   = ^{instr_in, w_reg_b};

  line_stager #(
    .WORD_W (DATA_CACHE_WIDTH),
    .WORDS  (WORDS_PER_LINE)
  ) u_stager (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_we       (w_stage_we),
    .i_word_idx (w_reg_a),
    .i_word     (DATA_CACHE_WIDTH'(w_imm)),
    .o_line     (w_staging)
  );

  // Sequencer state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Instruction decode and next-state selection
  always_comb begin
    w_next_state = r_state;
    w_stage_we   = 1'b0;
    w_sma        = 1'b0;
    w_sendl      = 1'b0;
    w_writeb     = 1'b0;
    w_direct     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_opcode)
            OP_SMA:   w_sma      = 1'b1;
            OP_LOADI: w_stage_we = 1'b1;
            OP_SENDL: w_sendl    = 1'b1;
            OP_WRITEB: begin
              w_writeb     = 1'b1;
              w_next_state = (READ_LATENCY == 0) ? ST_ISSUE : ST_READ_WAIT;
            end
`ifdef MEMSEQ_DIRECT_WRITE_EN
            OP_WRITE: w_direct   = 1'b1;
`else
            OP_WRITE: w_direct   = 1'b0;
`endif
            default:  w_next_state = ST_IDLE;
          endcase
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ_WAIT: begin
        if (r_cnt == CNT_W'(READ_LATENCY - 1)) begin
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_READ_WAIT;
        end
      end
      ST_ISSUE: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Address, cache-port, FMA-port and latency-counter registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt         <= {CNT_W{1'b0}};
      r_addr        <= {AW{1'b0}};
      r_cache_addr  <= {AW{1'b0}};
      r_cache_wdata <= {LINE_W{1'b0}};
      r_cache_we    <= 1'b0;
      r_fma_data    <= {LINE_W{1'b0}};
      r_fma_write   <= 1'b0;
      r_replace_c   <= 1'b0;
      r_fma_valid   <= 1'b0;
    end else begin
      r_cnt       <= (r_state == ST_READ_WAIT) ? r_cnt + CNT_W'(1) : {CNT_W{1'b0}};
      r_cache_we  <= w_sendl;
      r_fma_write <= w_direct || (r_state == ST_ISSUE);
      if (w_sma) begin
        r_addr <= w_imm_addr;
      end
      if (w_sendl) begin
        r_cache_addr  <= r_addr;
        r_cache_wdata <= w_staging;
      end else if (w_writeb) begin
        r_cache_addr  <= w_imm_addr;
      end
      if (w_writeb || w_direct) begin
        r_replace_c <= w_reg_a[0];
        r_fma_valid <= w_reg_b[0];
      end
      if (r_state == ST_ISSUE) begin
        r_fma_data <= cache_rdata_in;
      end else if (w_direct) begin
        r_fma_data <= w_staging;
      end
    end
  end

  assign ready_out         = (r_state == ST_IDLE);
  assign cache_addr_out    = r_cache_addr;
  assign cache_wdata_out   = r_cache_wdata;
  assign cache_we_out      = r_cache_we;
  assign fma_data_out      = r_fma_data;
  assign fma_write_out     = r_fma_write;
  assign fma_replace_c_out = r_replace_c;
  assign fma_valid_out     = r_fma_valid;

endmodule

// File: tb/tb_memory_sequencer.sv
// Self-checking bench for memory_sequencer: directed scenarios plus randomized
// instruction streams checked against a transaction-level reference model.
module tb_memory_sequencer;
  import gpu_isa_pkg::*;

  localparam int IW    = 32;
  localparam int DW    = 16;
  localparam int WPL   = 12;
  localparam int DEPTH = 4096;
  localparam int RL    = 2;
  localparam int LW    = WPL * DW;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [0:IW-1] instr = '0;
  logic          ivalid = 1'b0;
  logic          ready;
  logic [AW-1:0] caddr;
  logic [LW-1:0] cwdata;
  logic          cwe;
  logic [LW-1:0] crdata;
  logic [LW-1:0] fdata;
  logic          fwrite;
  logic          frc;
  logic          fvalid;

  // External cache BRAM with a two-cycle read pipeline and a bench preload port
  logic [LW-1:0] bram [0:DEPTH-1];
  logic [LW-1:0] rd1, rd2;
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [LW-1:0] tb_line = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int            m_addr;
  logic [DW-1:0] m_stage [WPL];
  logic [LW-1:0] ref_mem [8];
  logic [LW-1:0] m_fdata;
  logic          m_rc, m_fv;
  int            busy;
  int            pend_addr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cwe) bram[caddr] <= cwdata;
    else if (tb_we) bram[tb_addr] <= tb_line;
    rd1 <= bram[caddr];
    rd2 <= rd1;
  end
  assign crdata = rd2;

  memory_sequencer #(
    .INSTRUCTION_WIDTH (IW), .DATA_CACHE_WIDTH (DW), .WORDS_PER_LINE (WPL),
    .DATA_CACHE_DEPTH (DEPTH), .READ_LATENCY (RL)
  ) dut (
    .clk_in (clk), .rst_in (rst), .instr_in (instr), .instr_valid_in (ivalid),
    .ready_out (ready), .cache_addr_out (caddr), .cache_wdata_out (cwdata),
    .cache_we_out (cwe), .cache_rdata_in (crdata), .fma_data_out (fdata),
    .fma_write_out (fwrite), .fma_replace_c_out (frc), .fma_valid_out (fvalid)
  );

  function automatic logic [0:IW-1] mk(input logic [3:0] op, input int a, input int imm, input int b);
    logic [0:IW-1] x;
    x = '0;
    x[0:3]   = op;
    x[4:7]   = 4'(a);
    x[8:23]  = 16'(imm);
    x[24:27] = 4'(b);
    return x;
  endfunction

  // Line with given words; word 0 is the most significant
  function automatic logic [LW-1:0] stage_line();
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < WPL; i++) l = (l << DW) | LW'(m_stage[i]);
    return l;
  endfunction

  function automatic logic [LW-1:0] sendl_line();
    logic [LW-1:0] l;
    l = '0;
    l[LW-1 -: 16] = 16'h1234;
    l[15:0]       = 16'hBEEF;
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [0:IW-1] ins);
    instr  = ins;
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ivalid = 1'b0;
    step(); step();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if (cwe !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", cwe); end
    n_checks++; if (fwrite !== 1'b0) begin n_fail++; $display("FAIL reset_fwrite: got %b want 0", fwrite); end
    n_checks++; if (fdata !== '0) begin n_fail++; $display("FAIL reset_fdata: got %h want 0", fdata); end
    n_checks++; if ({frc, fvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {frc, fvalid}); end
    rst = 1'b0;
    issue(mk(OP_SENDL, 0, 0, 0));
    n_checks++; if ({cwe, caddr, cwdata} !== {1'b1, {AW{1'b0}}, {LW{1'b0}}}) begin
      n_fail++; $display("FAIL reset_staging: we=%b addr=%h wdata=%h want 1/0/0", cwe, caddr, cwdata);
    end
    step();
  endtask

  task automatic test_sendl();
    issue(mk(OP_SMA, 0, 'h0005, 0));
    issue(mk(OP_LOADI, 0, 'h1234, 0));
    issue(mk(OP_LOADI, 11, 'hBEEF, 0));
    issue(mk(OP_SENDL, 0, 0, 0));
    n_checks++; if (cwe !== 1'b1) begin n_fail++; $display("FAIL sendl_we: got %b want 1", cwe); end
    n_checks++; if (caddr !== AW'(5)) begin n_fail++; $display("FAIL sendl_addr: got %h want 5", caddr); end
    n_checks++; if (cwdata !== sendl_line()) begin n_fail++; $display("FAIL sendl_wdata: got %h want %h", cwdata, sendl_line()); end
    step();
    n_checks++; if (cwe !== 1'b0) begin n_fail++; $display("FAIL sendl_we_pulse: got %b want 0", cwe); end
  endtask

  task automatic test_loadi_oob();
    issue(mk(OP_LOADI, 12, 'hFFFF, 0));
    issue(mk(OP_SENDL, 0, 0, 0));
    n_checks++; if ({cwe, cwdata} !== {1'b1, sendl_line()}) begin
      n_fail++; $display("FAIL loadi_oob: we=%b wdata=%h want 1/%h", cwe, cwdata, sendl_line());
    end
    step();
  endtask

  task automatic test_writeb();
    issue(mk(OP_WRITEB, 1, 'h0005, 1));
    for (int k = 0; k < 3; k++) begin
      n_checks++; if ({ready, fwrite} !== 2'b00) begin
        n_fail++; $display("FAIL writeb_wait%0d: ready/fwrite=%b want 00", k, {ready, fwrite});
      end
      step();
    end
    n_checks++; if ({ready, fwrite, frc, fvalid} !== 4'b1111) begin
      n_fail++; $display("FAIL writeb_issue: ready/fwrite/rc/valid=%b want 1111", {ready, fwrite, frc, fvalid});
    end
    n_checks++; if (fdata !== sendl_line()) begin n_fail++; $display("FAIL writeb_data: got %h want %h", fdata, sendl_line()); end
    step();
    n_checks++; if ({fwrite, fdata} !== {1'b0, sendl_line()}) begin
      n_fail++; $display("FAIL writeb_hold: fwrite=%b data=%h", fwrite, fdata);
    end
  endtask

  task automatic test_writeb_reset();
    issue(mk(OP_WRITEB, 0, 'h0005, 1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if ({ready, fwrite, fvalid} !== 3'b100) begin
      n_fail++; $display("FAIL abort_reset: ready/fwrite/valid=%b want 100", {ready, fwrite, fvalid});
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++; if (fwrite !== 1'b0) begin n_fail++; $display("FAIL abort_nostrobe%0d: got %b want 0", k, fwrite); end
    end
  endtask

  task automatic test_write();
    logic [LW-1:0] exp;
    exp = '0;
    exp[LW-1-3*DW -: DW] = 16'h0042;
    issue(mk(OP_LOADI, 3, 'h0042, 0));
    issue(mk(OP_WRITE, 1, 0, 0));
`ifdef MEMSEQ_DIRECT_WRITE_EN
    n_checks++; if ({fwrite, frc, fvalid} !== 3'b110) begin
      n_fail++; $display("FAIL write_strobe: fwrite/rc/valid=%b want 110", {fwrite, frc, fvalid});
    end
    n_checks++; if (fdata !== exp) begin n_fail++; $display("FAIL write_data: got %h want %h", fdata, exp); end
`else
    n_checks++; if ({fwrite, frc, fvalid} !== 3'b000) begin
      n_fail++; $display("FAIL write_noop: fwrite/rc/valid=%b want 000", {fwrite, frc, fvalid});
    end
    n_checks++; if (fdata !== '0) begin n_fail++; $display("FAIL write_noop_data: got %h want 0", fdata); end
`endif
    step();
    n_checks++; if (fwrite !== 1'b0) begin n_fail++; $display("FAIL write_pulse: got %b want 0", fwrite); end
  endtask

  task automatic test_hold_valid();
    int low;
    issue(mk(OP_WRITEB, 0, 'h0002, 0));
    instr  = mk(OP_SENDL, 0, 0, 0);
    ivalid = 1'b1;
    low = 0;
    while (ready === 1'b0 && low < 10) begin
      n_checks++; if (cwe !== 1'b0) begin n_fail++; $display("FAIL hold_early_consume: we=%b want 0", cwe); end
      low++;
      step();
    end
    n_checks++; if (low !== 3) begin n_fail++; $display("FAIL hold_busy_cycles: got %0d want 3", low); end
    step();
    ivalid = 1'b0;
    n_checks++; if ({cwe, caddr} !== {1'b1, {AW{1'b0}}}) begin
      n_fail++; $display("FAIL hold_consume: we=%b addr=%h want 1/0", cwe, caddr);
    end
    step();
    n_checks++; if (cwe !== 1'b0) begin n_fail++; $display("FAIL hold_once: we=%b want 0", cwe); end
  endtask

  task automatic model_reset();
    m_addr = 0; m_fdata = '0; m_rc = 1'b0; m_fv = 1'b0; busy = 0; pend_addr = 0;
    for (int i = 0; i < WPL; i++) m_stage[i] = '0;
  endtask

  task automatic test_random();
    rst = 1'b1; ivalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tb_we = 1'b1; tb_addr = AW'(i);
      for (int k = 0; k < LW / 32; k++) tb_line = (tb_line << 32) | LW'($urandom);
      ref_mem[i] = tb_line;
      step();
    end
    tb_we = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    for (int it = 0; it < 600; it++) begin
      logic r, v, acc, exp_we, exp_fw;
      logic [3:0] op;
      int a, b, imm, exp_ad;
      logic [LW-1:0] exp_wd;
      r   = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 3) != 0);
      op  = 4'($urandom_range(0, 15));
      a   = $urandom_range(0, 15);
      b   = $urandom_range(0, 15);
      imm = $urandom_range(0, 65535);
      if (op == OP_SMA || op == OP_WRITEB) imm = (imm & 'hF000) | $urandom_range(0, 7);
      rst = r; instr = mk(op, a, imm, b); ivalid = v;
      acc = v && !r && (busy == 0);
      step();
      exp_we = 1'b0; exp_fw = 1'b0; exp_ad = 0; exp_wd = '0;
      if (r) begin
        model_reset();
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin exp_fw = 1'b1; m_fdata = ref_mem[pend_addr]; end
      end else if (acc) begin
        case (op)
          OP_SMA:   m_addr = imm % DEPTH;
          OP_LOADI: if (a < WPL) m_stage[a] = 16'(imm);
          OP_SENDL: begin exp_we = 1'b1; exp_ad = m_addr; exp_wd = stage_line(); ref_mem[m_addr] = exp_wd; end
          OP_WRITEB: begin busy = RL + 1; pend_addr = imm % DEPTH; m_rc = 1'(a & 1); m_fv = 1'(b & 1); end
`ifdef MEMSEQ_DIRECT_WRITE_EN
          OP_WRITE: begin exp_fw = 1'b1; m_fdata = stage_line(); m_rc = 1'(a & 1); m_fv = 1'(b & 1); end
`endif
          default: ;
        endcase
      end
      n_checks++; if (ready !== (busy == 0)) begin n_fail++; $display("FAIL rnd%0d_ready: got %b want %b", it, ready, busy == 0); end
      n_checks++; if (cwe !== exp_we) begin n_fail++; $display("FAIL rnd%0d_we: got %b want %b", it, cwe, exp_we); end
      if (exp_we) begin
        n_checks++; if ({caddr, cwdata} !== {AW'(exp_ad), exp_wd}) begin
          n_fail++; $display("FAIL rnd%0d_write: addr=%h data=%h want %h/%h", it, caddr, cwdata, exp_ad, exp_wd);
        end
      end
      n_checks++; if (fwrite !== exp_fw) begin n_fail++; $display("FAIL rnd%0d_fwrite: got %b want %b", it, fwrite, exp_fw); end
      n_checks++; if ({fdata, frc, fvalid} !== {m_fdata, m_rc, m_fv}) begin
        n_fail++; $display("FAIL rnd%0d_fma: data=%h rc=%b v=%b want %h/%b/%b", it, fdata, frc, fvalid, m_fdata, m_rc, m_fv);
      end
      n_checks++; if ((cwe & fwrite) !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_exclusive: we and fwrite both high", it); end
    end
    rst = 1'b0; ivalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sendl();
    test_loadi_oob();
    test_writeb();
    test_writeb_reset();
    test_write();
    test_hold_valid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
